kbd_port_fifo: RTL and testbench

KBD_PORT_FIFO -- requirements
Module: kbd_port_fifo

---
 rtl/kbd_port_fifo_if.sv | 23 ++
 rtl/kbd_port_fifo.sv | 137 +++++++++++++
 tb/tb_kbd_port_fifo.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/kbd_port_fifo_if.sv
// Keyboard FIFO bus: PS/2 scancode input side plus the CPU I/O-port side.
// The slave modport is the FIFO itself; the master modport is whoever drives it.
interface kbd_port_fifo_if;
    logic [7:0] ps2_data;
    logic       ps2_data_en;
    logic [7:0] ascii;
    logic [7:0] port_a;
    logic [7:0] port_o;
    logic       port_w;
    logic       port_rd;
    logic [7:0] port_i;
    logic       irq;

    modport master (
        output ps2_data, ps2_data_en, ascii, port_a, port_o, port_w, port_rd,
        input  port_i, irq
    );

    modport slave (
        input  ps2_data, ps2_data_en, ascii, port_a, port_o, port_w, port_rd,
        output port_i, irq
    );
endinterface

// File: rtl/kbd_port_fifo.sv
// Keyboard event FIFO behind two CPU I/O ports (data and status/control).
// Optional macro KBD_IRQ_EN enables a registered "FIFO non-empty" interrupt.
module kbd_port_fifo #(
    parameter int         DEPTH_LOG2 = 4,
    parameter logic [7:0] PORT_DATA  = 8'hFE,
    parameter logic [7:0] PORT_STAT  = 8'hFF
) (
    input logic           clk,
    input logic           reset,
    kbd_port_fifo_if.slave bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int PW    = DEPTH_LOG2 + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count;
    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic          ovf_q, ovf_d;
    logic          rel_q, rel_d;
    logic [7:0]    port_i_q, port_i_d;

    logic          empty, full;
    logic          is_f0, is_e0, push_req, push_ok, pop;
    logic          flush, clr_ovf;
    logic [7:0]    event_byte;
    logic          unused_port_o;

    assign unused_port_o = ^bus.port_o[5:0];

    always_comb begin
        count      = wr_ptr_q - rd_ptr_q;
        empty      = (count == '0);
        full       = (count == PW'(DEPTH));
        is_f0      = (bus.ps2_data == 8'hF0);
        is_e0      = (bus.ps2_data == 8'hE0);
        push_req   = bus.ps2_data_en && !is_f0 && !is_e0;
        // Extended-range translations (0xEx) carry their own meaning in bit 7.
        event_byte = (bus.ascii[7:4] == 4'hE) ? bus.ascii : {rel_q, bus.ascii[6:0]};
        pop        = bus.port_rd && (bus.port_a == PORT_DATA) && !empty;
        push_ok    = push_req && (!full || pop);
        flush      = bus.port_w && (bus.port_a == PORT_STAT) && bus.port_o[7];
        clr_ovf    = bus.port_w && (bus.port_a == PORT_STAT) && bus.port_o[6];
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        ovf_d    = ovf_q;
        rel_d    = rel_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            rel_d    = 1'b0;
        end else begin
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push_ok) begin
                mem_d[wr_ptr_q[DEPTH_LOG2-1:0]] = event_byte;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            // A drop in the same cycle as a clear-only write still leaves overflow set.
            if (clr_ovf) begin
                ovf_d = 1'b0;
            end
            if (push_req && !push_ok) begin
                ovf_d = 1'b1;
            end
            if (push_req) begin
                rel_d = 1'b0;
            end else if (bus.ps2_data_en && is_f0) begin
                rel_d = 1'b1;
            end
        end
    end

    always_comb begin
        port_i_d = port_i_q;
        if (bus.port_rd) begin
            if (bus.port_a == PORT_DATA) begin
                port_i_d = empty ? 8'h00 : mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
            end else if (bus.port_a == PORT_STAT) begin
                port_i_d = {!empty, ovf_q, 6'(count)};
            end else begin
                port_i_d = 8'hFF;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            rel_q    <= 1'b0;
            port_i_q <= 8'hFF;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            rel_q    <= rel_d;
            port_i_q <= port_i_d;
        end
    end

    // Storage needs no reset: the pointers decide which entries are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.port_i = port_i_q;

`ifdef KBD_IRQ_EN
    logic irq_q, irq_d;

    always_comb begin
        irq_d = !empty;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign bus.irq = irq_q;
`else
    assign bus.irq = 1'b0;
`endif

endmodule

// File: tb/tb_kbd_port_fifo.sv
// Directed bench for kbd_port_fifo (DEPTH_LOG2=2) with a queue-based scoreboard.
// Builds with or without KBD_IRQ_EN; the irq model follows the macro.
module tb_kbd_port_fifo;
    localparam logic [7:0] PORT_DATA = 8'hFE;
    localparam logic [7:0] PORT_STAT = 8'hFF;
    localparam int         DEPTH     = 4;

    logic clk = 1'b0;
    logic reset;

    kbd_port_fifo_if bus ();

    kbd_port_fifo #(
        .DEPTH_LOG2(2),
        .PORT_DATA (PORT_DATA),
        .PORT_STAT (PORT_STAT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] sb[$];
    logic       m_ovf = 1'b0;
    logic       m_rel = 1'b0;
    logic       m_irq = 1'b0;
    logic [7:0] exp_port_i = 8'hFF;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic check_irq(input string tag);
        checkOutput(tag, {7'b0, bus.irq}, {7'b0, m_irq});
    endtask

    // One clock of stimulus; the model is advanced with the same inputs.
    task automatic applyStimulus(input logic en, input logic [7:0] ps2, input logic [7:0] asc,
                                 input logic rd, input logic w,
                                 input logic [7:0] addr, input logic [7:0] wdata);
        logic       do_pop, do_flush, push_req;
        logic [7:0] ev;
`ifdef KBD_IRQ_EN
        m_irq = (sb.size() != 0);
`else
        m_irq = 1'b0;
`endif
        if (rd) begin
            if (addr == PORT_DATA)
                exp_port_i = (sb.size() != 0) ? sb[0] : 8'h00;
            else if (addr == PORT_STAT)
                exp_port_i = {sb.size() != 0, m_ovf, 6'(sb.size())};
            else
                exp_port_i = 8'hFF;
        end
        do_pop   = rd && (addr == PORT_DATA) && (sb.size() != 0);
        do_flush = w && (addr == PORT_STAT) && wdata[7];
        push_req = en && (ps2 != 8'hF0) && (ps2 != 8'hE0);
        if (do_pop) void'(sb.pop_front());
        if (do_flush) begin
            sb.delete();
            m_ovf = 1'b0;
            m_rel = 1'b0;
        end else begin
            if (w && (addr == PORT_STAT) && wdata[6]) m_ovf = 1'b0;
            if (push_req) begin
                ev = (asc[7:4] == 4'hE) ? asc : {m_rel, asc[6:0]};
                if (sb.size() < DEPTH) sb.push_back(ev);
                else m_ovf = 1'b1;
                m_rel = 1'b0;
            end else if (en && ps2 == 8'hF0) begin
                m_rel = 1'b1;
            end
        end
        bus.ps2_data    = ps2;
        bus.ps2_data_en = en;
        bus.ascii       = asc;
        bus.port_rd     = rd;
        bus.port_w      = w;
        bus.port_a      = addr;
        bus.port_o      = wdata;
        @(posedge clk);
        #1;
        bus.ps2_data_en = 1'b0;
        bus.port_rd     = 1'b0;
        bus.port_w      = 1'b0;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic strobe(input logic [7:0] ps2, input logic [7:0] asc);
        applyStimulus(1'b1, ps2, asc, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic rd_port(input logic [7:0] addr, input string tag);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, addr, 8'h00);
        checkOutput(tag, bus.port_i, exp_port_i);
    endtask

    task automatic wr_port(input logic [7:0] addr, input logic [7:0] data);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, addr, data);
    endtask

    initial begin
        reset           = 1'b1;
        bus.ps2_data    = 8'h00;
        bus.ps2_data_en = 1'b0;
        bus.ascii       = 8'h00;
        bus.port_a      = 8'h00;
        bus.port_o      = 8'h00;
        bus.port_w      = 1'b0;
        bus.port_rd     = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_port_i", bus.port_i, 8'hFF);
        checkOutput("reset_irq", {7'b0, bus.irq}, 8'h00);
        reset = 1'b0;
        rd_port(PORT_STAT, "post_reset_stat");

        $display("[TB] single key press");
        strobe(8'h1C, 8'h61);
        rd_port(PORT_DATA, "press_data");
        rd_port(PORT_STAT, "press_stat");

        $display("[TB] release prefix");
        strobe(8'hF0, 8'h00);
        strobe(8'h1C, 8'h61);
        strobe(8'h1C, 8'h61);
        rd_port(PORT_DATA, "release_data");
        rd_port(PORT_DATA, "release_cleared");
        strobe(8'hF0, 8'h00);
        strobe(8'hE0, 8'h00);
        strobe(8'h12, 8'h53);
        strobe(8'hF0, 8'h00);
        strobe(8'h75, 8'hE5);
        strobe(8'h1C, 8'h61);
        rd_port(PORT_DATA, "e0_keeps_release");
        rd_port(PORT_DATA, "ext_ascii_kept");
        rd_port(PORT_DATA, "after_ext_plain");
        idle();
        checkOutput("port_i_holds", bus.port_i, exp_port_i);

        $display("[TB] overflow");
        for (int i = 0; i < 5; i++) strobe(8'h16 + 8'(i), 8'h31 + 8'(i));
        idle();
        check_irq("irq_full");
        rd_port(PORT_STAT, "ovf_stat");
        for (int i = 0; i < 5; i++) rd_port(PORT_DATA, $sformatf("ovf_data%0d", i));
        rd_port(PORT_STAT, "ovf_sticky_stat");
        wr_port(PORT_STAT, 8'h40);
        rd_port(PORT_STAT, "ovf_clear_stat");
        check_irq("irq_empty");

        $display("[TB] push and pop while full");
        for (int i = 0; i < 4; i++) strobe(8'h20 + 8'(i), 8'h41 + 8'(i));
        applyStimulus(1'b1, 8'h2A, 8'h45, 1'b1, 1'b0, PORT_DATA, 8'h00);
        checkOutput("full_pushpop_data", bus.port_i, exp_port_i);
        rd_port(PORT_STAT, "full_pushpop_stat");
        for (int i = 0; i < 4; i++) rd_port(PORT_DATA, $sformatf("full_drain%0d", i));

        $display("[TB] writes without effect");
        strobe(8'h1C, 8'h61);
        strobe(8'h32, 8'h62);
        wr_port(PORT_DATA, 8'h80);
        wr_port(PORT_STAT, 8'h20);
        wr_port(8'h10, 8'hC0);
        rd_port(PORT_STAT, "noeffect_stat");

        $display("[TB] flush");
        strobe(8'h21, 8'h63);
        strobe(8'hF0, 8'h00);
        idle();
        check_irq("irq_before_flush");
        wr_port(PORT_STAT, 8'h80);
        check_irq("irq_flush_cycle");
        idle();
        check_irq("irq_after_flush");
        rd_port(PORT_STAT, "flush_stat");
        strobe(8'h1C, 8'h61);
        rd_port(PORT_DATA, "flush_cleared_release");
        applyStimulus(1'b1, 8'h1C, 8'h61, 1'b0, 1'b1, PORT_STAT, 8'h80);
        rd_port(PORT_STAT, "flush_beats_push");

        $display("[TB] reset mid-burst");
        strobe(8'h1C, 8'h61);
        strobe(8'h32, 8'h62);
        reset           = 1'b1;
        bus.ps2_data    = 8'h21;
        bus.ascii       = 8'h63;
        bus.ps2_data_en = 1'b1;
        @(posedge clk);
        #1;
        bus.ps2_data_en = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        m_ovf      = 1'b0;
        m_rel      = 1'b0;
        m_irq      = 1'b0;
        exp_port_i = 8'hFF;
        checkOutput("midburst_port_i", bus.port_i, exp_port_i);
        check_irq("midburst_irq");
        rd_port(PORT_STAT, "midburst_stat");
        rd_port(8'h10, "other_port");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
